// File: rtl/yags_pkg.sv
// Shared types and helpers for the YAGS predictor resolution/training path.
// Snapshot field widths are the canonical predictor widths used by yags_update_unit.
package yags_pkg;

  localparam int unsigned SNAP_PC_W    = 32;
  localparam int unsigned SNAP_GHR_W   = 8;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  typedef struct packed {
    logic [SNAP_PC_W-1:0]  pc;
    logic [SNAP_GHR_W-1:0] ghr;
    logic [1:0]            choice_ctr;
    logic                  cache_hit;
    logic [1:0]            cache_ctr;
    logic                  pred_taken;
    logic [SNAP_PC_W-1:0]  pred_tgt;
  } snapshot_t;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST)  ? ST  : ctr + 2'd1;
    else       return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/yags_snapshot_fifo.sv
// In-flight prediction snapshot queue; head is the oldest unresolved branch.
// Clear empties the queue in one cycle and overrides push/pop.
module yags_snapshot_fifo
  import yags_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type T = snapshot_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  input  logic clear,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  assign head  = mem[rd_ptr];
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/yags_update_unit.sv
// YAGS resolution/training: detects mispredicts, repairs GHR and issues
// one registered choice-PHT / direction-cache write per resolved branch.
module yags_update_unit
  import yags_pkg::*;
#(
  parameter int unsigned PC_W         = SNAP_PC_W,
  parameter int unsigned GHR_W        = SNAP_GHR_W,
  parameter int unsigned CHOICE_IDX_W = 10,
  parameter int unsigned CACHE_IDX_W  = 8,
  parameter int unsigned TAG_W        = 6,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push_valid_i,
  output logic                    push_ready_o,
  input  logic [PC_W-1:0]         push_pc_i,
  input  logic [GHR_W-1:0]        push_ghr_i,
  input  logic [1:0]              push_choice_ctr_i,
  input  logic                    push_cache_hit_i,
  input  logic [1:0]              push_cache_ctr_i,
  input  logic                    push_pred_taken_i,
  input  logic [PC_W-1:0]         push_pred_tgt_i,
  input  logic                    res_valid_i,
  input  logic                    res_taken_i,
  input  logic [PC_W-1:0]         res_tgt_i,
  input  logic                    flush_i,
  output logic                    mispredict_o,
  output logic [PC_W-1:0]         redirect_pc_o,
  output logic [GHR_W-1:0]        ghr_restore_o,
  output logic                    choice_we_o,
  output logic [CHOICE_IDX_W-1:0] choice_idx_o,
  output logic [1:0]              choice_wdata_o,
  output logic                    cache_we_o,
  output logic                    cache_sel_o,
  output logic [CACHE_IDX_W-1:0]  cache_idx_o,
  output logic [TAG_W-1:0]        cache_tag_o,
  output logic [1:0]              cache_wdata_o,
  output logic                    err_o
);

  snapshot_t push_snap;
  snapshot_t head;
  logic      full, empty;
  logic      do_push, do_pop, mis_now, clear, cd;

  always_comb begin
    push_snap            = '0;
    push_snap.pc         = push_pc_i;
    push_snap.ghr        = push_ghr_i;
    push_snap.choice_ctr = push_choice_ctr_i;
    push_snap.cache_hit  = push_cache_hit_i;
    push_snap.cache_ctr  = push_cache_ctr_i;
    push_snap.pred_taken = push_pred_taken_i;
    push_snap.pred_tgt   = push_pred_tgt_i;
  end

  assign push_ready_o = !full;
  assign cd           = head.choice_ctr[1];
  assign do_pop       = res_valid_i && !empty && !flush_i;
  assign mis_now      = (head.pred_taken != res_taken_i) ||
                        (head.pred_taken && res_taken_i && (head.pred_tgt != res_tgt_i));
  // A mispredict squashes everything younger, including a same-cycle push.
  assign clear        = flush_i || (do_pop && mis_now);
  assign do_push      = push_valid_i && push_ready_o && !clear;

  yags_snapshot_fifo #(
    .DEPTH (DEPTH),
    .T     (snapshot_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (do_push),
    .push_data (push_snap),
    .pop       (do_pop),
    .clear     (clear),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mispredict_o   <= 1'b0;
      redirect_pc_o  <= '0;
      ghr_restore_o  <= '0;
      choice_we_o    <= 1'b0;
      choice_idx_o   <= '0;
      choice_wdata_o <= '0;
      cache_we_o     <= 1'b0;
      cache_sel_o    <= 1'b0;
      cache_idx_o    <= '0;
      cache_tag_o    <= '0;
      cache_wdata_o  <= '0;
      err_o          <= 1'b0;
    end else begin
      mispredict_o <= 1'b0;
      choice_we_o  <= 1'b0;
      cache_we_o   <= 1'b0;
      if (res_valid_i && empty && !flush_i) err_o <= 1'b1;
      if (do_pop) begin
        mispredict_o   <= mis_now;
        redirect_pc_o  <= res_taken_i ? res_tgt_i : head.pc + PC_W'(4);
        ghr_restore_o  <= {head.ghr[GHR_W-2:0], res_taken_i};
        // Choice PHT is left alone when the consulted cache already overrode it correctly.
        choice_we_o    <= !((cd != res_taken_i) && head.cache_hit &&
                            (head.cache_ctr[1] == res_taken_i));
        choice_idx_o   <= head.pc[CHOICE_IDX_W+1:2];
        choice_wdata_o <= sat_update(head.choice_ctr, res_taken_i);
        cache_we_o     <= head.cache_hit || (cd != res_taken_i);
        cache_sel_o    <= ~cd;
        cache_idx_o    <= head.pc[CACHE_IDX_W+1:2] ^ head.ghr[CACHE_IDX_W-1:0];
        cache_tag_o    <= head.pc[CACHE_IDX_W+TAG_W+1:CACHE_IDX_W+2];
        cache_wdata_o  <= head.cache_hit ? sat_update(head.cache_ctr, res_taken_i)
                                         : (res_taken_i ? WT : WNT);
      end
    end
  end

endmodule

// File: tb/tb_yags_update_unit.sv
// Scoreboard bench for yags_update_unit: stimulus queues expected write/redirect
// responses, a negedge monitor pops and compares whenever a strobe appears.
module tb_yags_update_unit;

  logic        clk;
  logic        reset;
  logic        push_valid_i;
  logic        push_ready_o;
  logic [31:0] push_pc_i;
  logic [7:0]  push_ghr_i;
  logic [1:0]  push_choice_ctr_i;
  logic        push_cache_hit_i;
  logic [1:0]  push_cache_ctr_i;
  logic        push_pred_taken_i;
  logic [31:0] push_pred_tgt_i;
  logic        res_valid_i;
  logic        res_taken_i;
  logic [31:0] res_tgt_i;
  logic        flush_i;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic [7:0]  ghr_restore_o;
  logic        choice_we_o;
  logic [9:0]  choice_idx_o;
  logic [1:0]  choice_wdata_o;
  logic        cache_we_o;
  logic        cache_sel_o;
  logic [7:0]  cache_idx_o;
  logic [5:0]  cache_tag_o;
  logic [1:0]  cache_wdata_o;
  logic        err_o;

  yags_update_unit #(
    .PC_W         (32),
    .GHR_W        (8),
    .CHOICE_IDX_W (10),
    .CACHE_IDX_W  (8),
    .TAG_W        (6),
    .DEPTH        (4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .push_valid_i      (push_valid_i),
    .push_ready_o      (push_ready_o),
    .push_pc_i         (push_pc_i),
    .push_ghr_i        (push_ghr_i),
    .push_choice_ctr_i (push_choice_ctr_i),
    .push_cache_hit_i  (push_cache_hit_i),
    .push_cache_ctr_i  (push_cache_ctr_i),
    .push_pred_taken_i (push_pred_taken_i),
    .push_pred_tgt_i   (push_pred_tgt_i),
    .res_valid_i       (res_valid_i),
    .res_taken_i       (res_taken_i),
    .res_tgt_i         (res_tgt_i),
    .flush_i           (flush_i),
    .mispredict_o      (mispredict_o),
    .redirect_pc_o     (redirect_pc_o),
    .ghr_restore_o     (ghr_restore_o),
    .choice_we_o       (choice_we_o),
    .choice_idx_o      (choice_idx_o),
    .choice_wdata_o    (choice_wdata_o),
    .cache_we_o        (cache_we_o),
    .cache_sel_o       (cache_sel_o),
    .cache_idx_o       (cache_idx_o),
    .cache_tag_o       (cache_tag_o),
    .cache_wdata_o     (cache_wdata_o),
    .err_o             (err_o)
  );

  typedef struct {
    logic        mis;
    logic [31:0] redir;
    logic [7:0]  ghr;
    logic        cwe;
    logic [9:0]  cidx;
    logic [1:0]  cwd;
    logic        kwe;
    logic        ksel;
    logic [7:0]  kidx;
    logic [5:0]  ktag;
    logic [1:0]  kwd;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset === 1'b1 && (choice_we_o || cache_we_o || mispredict_o)) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_strobe: got mis=%0b cwe=%0b kwe=%0b, want no strobe (t=%0t)",
                 mispredict_o, choice_we_o, cache_we_o, $time);
      end else begin
        e = q.pop_front();
        check("mispredict", 32'(mispredict_o), 32'(e.mis));
        if (e.mis) check("redirect_pc", redirect_pc_o, e.redir);
        check("ghr_restore", 32'(ghr_restore_o), 32'(e.ghr));
        check("choice_we", 32'(choice_we_o), 32'(e.cwe));
        if (e.cwe) begin
          check("choice_idx", 32'(choice_idx_o), 32'(e.cidx));
          check("choice_wdata", 32'(choice_wdata_o), 32'(e.cwd));
        end
        check("cache_we", 32'(cache_we_o), 32'(e.kwe));
        if (e.kwe) begin
          check("cache_sel", 32'(cache_sel_o), 32'(e.ksel));
          check("cache_idx", 32'(cache_idx_o), 32'(e.kidx));
          check("cache_tag", 32'(cache_tag_o), 32'(e.ktag));
          check("cache_wdata", 32'(cache_wdata_o), 32'(e.kwd));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic mis, input logic [31:0] redir, input logic [7:0] ghr,
                              input logic cwe, input logic [9:0] cidx, input logic [1:0] cwd,
                              input logic kwe, input logic ksel, input logic [7:0] kidx,
                              input logic [5:0] ktag, input logic [1:0] kwd);
    exp_t e;
    e.mis = mis; e.redir = redir; e.ghr = ghr;
    e.cwe = cwe; e.cidx = cidx; e.cwd = cwd;
    e.kwe = kwe; e.ksel = ksel; e.kidx = kidx; e.ktag = ktag; e.kwd = kwd;
    return e;
  endfunction

  // Entry k of the ordering tests: pc=0x1000+4k (choice idx k), ghr=k, correctly predicted taken.
  function automatic exp_t exp_ok(input int k);
    return mk(1'b0, 32'h0, 8'((k << 1) | 1), 1'b1, 10'(k), 2'd3, 1'b0, 1'b0, 8'h0, 6'h0, 2'd0);
  endfunction

  task automatic drive_push(input logic [31:0] pc, input logic [7:0] ghr, input logic [1:0] ch,
                            input logic hit, input logic [1:0] cc, input logic pt,
                            input logic [31:0] tgt);
    push_valid_i = 1'b1; push_pc_i = pc; push_ghr_i = ghr; push_choice_ctr_i = ch;
    push_cache_hit_i = hit; push_cache_ctr_i = cc; push_pred_taken_i = pt; push_pred_tgt_i = tgt;
  endtask

  task automatic drive_push_k(input int k);
    drive_push(32'h1000 + 32'(4 * k), 8'(k), 2'd2, 1'b0, 2'd0, 1'b1, 32'h2000 + 32'(k));
  endtask

  task automatic drive_res(input logic tk, input logic [31:0] tgt);
    res_valid_i = 1'b1; res_taken_i = tk; res_tgt_i = tgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    push_valid_i = 1'b0; res_valid_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(push_ready_o), 32'd1);
    check({tag, "_mis"}, 32'(mispredict_o), 32'd0);
    check({tag, "_redirect"}, redirect_pc_o, 32'd0);
    check({tag, "_ghr"}, 32'(ghr_restore_o), 32'd0);
    check({tag, "_strobes"}, 32'({choice_we_o, cache_we_o}), 32'd0);
    check({tag, "_data"}, 32'({choice_idx_o, choice_wdata_o, cache_sel_o, cache_idx_o,
                               cache_tag_o, cache_wdata_o}), 32'd0);
    check({tag, "_err"}, 32'(err_o), 32'd0);
  endtask

  task automatic fill_and_check_ready(input int k0, input string tag);
    for (int i = 0; i < 4; i++) begin
      drive_push_k(k0 + i);
      tick();
      check(tag, 32'(push_ready_o), (i < 3) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int order [9] = '{1, 2, 3, 5, 6, 7, 8, 9, 10};
    reset = 1'b0; push_valid_i = 1'b0; res_valid_i = 1'b0; flush_i = 1'b0;
    push_pc_i = '0; push_ghr_i = '0; push_choice_ctr_i = '0; push_cache_hit_i = 1'b0;
    push_cache_ctr_i = '0; push_pred_taken_i = 1'b0; push_pred_tgt_i = '0;
    res_taken_i = 1'b0; res_tgt_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b1;
    tick();

    // Correctly predicted taken, cache miss, choice agrees.
    drive_push(32'h100, 8'h00, 2'd2, 1'b0, 2'd0, 1'b1, 32'h200); tick();
    q.push_back(mk(1'b0, 32'h0, 8'h01, 1'b1, 10'h40, 2'd3, 1'b0, 1'b0, 8'h0, 6'h0, 2'd0));
    drive_res(1'b1, 32'h200); tick();

    // Direction mispredict, miss with choice wrong: allocate in NT cache.
    drive_push(32'h100, 8'h00, 2'd2, 1'b0, 2'd0, 1'b1, 32'h200); tick();
    q.push_back(mk(1'b1, 32'h104, 8'h00, 1'b1, 10'h40, 2'd1, 1'b1, 1'b0, 8'h40, 6'h00, 2'd1));
    drive_res(1'b0, 32'h0); tick();

    // Cache hit overrides wrong choice: choice PHT untouched.
    drive_push(32'h0000C5A4, 8'h3C, 2'd3, 1'b1, 2'd0, 1'b0, 32'h0); tick();
    q.push_back(mk(1'b0, 32'h0, 8'h78, 1'b0, 10'h169, 2'd0, 1'b1, 1'b0, 8'h55, 6'h31, 2'd0));
    drive_res(1'b0, 32'h0); tick();

    // Target mispredict squashes the two younger entries and a same-cycle push.
    drive_push(32'h100, 8'h00, 2'd2, 1'b0, 2'd0, 1'b1, 32'h200); tick();
    drive_push(32'h104, 8'h01, 2'd1, 1'b0, 2'd0, 1'b0, 32'h0);   tick();
    drive_push(32'h108, 8'h02, 2'd1, 1'b0, 2'd0, 1'b0, 32'h0);   tick();
    q.push_back(mk(1'b1, 32'h300, 8'h01, 1'b1, 10'h40, 2'd3, 1'b0, 1'b0, 8'h0, 6'h0, 2'd0));
    drive_res(1'b1, 32'h300);
    drive_push(32'h10C, 8'h03, 2'd1, 1'b0, 2'd0, 1'b0, 32'h0);
    tick();
    check("squash_ready", 32'(push_ready_o), 32'd1);

    // Fill, refused 5th push, then in-order push/resolve pairs across wrap.
    fill_and_check_ready(0, "fill_ready");
    drive_push_k(4); tick();
    check("full_ready_hold", 32'(push_ready_o), 32'd0);
    q.push_back(exp_ok(0));
    drive_res(1'b1, 32'h2000); tick();
    check("after_pop_ready", 32'(push_ready_o), 32'd1);
    for (int i = 0; i < 9; i++) begin
      if (i < 6) drive_push_k(5 + i);
      q.push_back(exp_ok(order[i]));
      drive_res(1'b1, 32'h2000 + 32'(order[i]));
      tick();
    end
    tick();

    // Resolve while empty: sticky error, no strobes.
    drive_res(1'b1, 32'h0); tick();
    tick();
    check("err_sticky", 32'(err_o), 32'd1);

    // Flush beats a simultaneous push and resolve.
    drive_push_k(20); tick();
    drive_push_k(21); tick();
    drive_push_k(22); drive_res(1'b1, 32'h2000 + 32'd20); flush_i = 1'b1; tick();
    tick();
    check("flush_no_write", 32'({choice_we_o, cache_we_o, mispredict_o}), 32'd0);
    fill_and_check_ready(30, "post_flush_ready");

    // Reset lands while a registered write is being presented.
    drive_res(1'b1, 32'h2000 + 32'd30); tick();
    check("pre_reset_strobe", 32'(choice_we_o), 32'd1);
    #1 reset = 1'b0;
    #1 check_idle_outputs("midreset");
    tick();
    reset = 1'b1;
    tick();
    check("post_reset_ready", 32'(push_ready_o), 32'd1);

    tick();
    check("sb_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
